jtag_capture_update_chain: RTL and testbench

- Parametrised JTAG data-register chain; successor of the 1-bit bypass chain.
- Provides a WIDTH-bit capture/shift/update register plus a 1-bit bypass path, selected per scan at capture time.
- Adds shift-length checking and a sticky illegal-control flag.
- Sits between the TAP controller's chainIn control/data and the next chain's data input; one instance per DR (IDCODE, DTMCS, DMI-style).

---
 rtl/jtag_chain_pkg.sv | 21 ++
 rtl/jtag_shift_counter.sv | 27 ++
 rtl/jtag_capture_update_chain.sv | 151 +++++++++++++++
 tb/tb_jtag_capture_update_chain.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_chain_pkg.sv
// Shared definitions for JTAG data-register chains.
//   chain_mode_e     : latched chain mode (BYPASS=1, DATA=0)
//   *_RESET_VALUE    : default power-on contents for IDCODE / DTMCS chains
//   strobes_legal()  : true when at most one of capture/shift/update is high
package jtag_chain_pkg;

  typedef enum logic {
    CHAIN_DATA   = 1'b0,
    CHAIN_BYPASS = 1'b1
  } chain_mode_e;

  localparam logic [31:0] IDCODE_RESET_VALUE = 32'h0000_0001;
  localparam logic [31:0] DTMCS_RESET_VALUE  = 32'h0000_0071;

  function automatic logic strobes_legal(input logic capture,
                                         input logic shift,
                                         input logic update);
    return !((capture & shift) | (capture & update) | (shift & update));
  endfunction

endpackage

// File: rtl/jtag_shift_counter.sv
// Saturating shifted-bit counter.
//   clock, reset (async active-low)
//   clear : synchronous clear to zero (has priority over inc)
//   inc   : increment, holding at MAX once reached
//   count : current value
module jtag_shift_counter #(
  parameter int unsigned MAX   = 9,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != CNT_W'(MAX))) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/jtag_capture_update_chain.sv
// JTAG data-register chain: WIDTH-bit capture/shift/update register with a
// 1-bit bypass path chosen at capture time, shift-length checking and a
// sticky illegal-control flag.
//   clock, reset (async active-low)
//   io_chainIn_shift/data/capture/update : TAP control strobes and TDI data
//   io_bypass        : mode request, sampled on capture
//   io_capture_bits  : parallel value loaded on capture
//   io_err_clear     : clears io_ctrl_err
//   io_chainOut_data : TDO-side serial data (registers only)
//   io_update_bits   : last updated value
//   io_update_valid  : one-cycle pulse after an accepted update
//   io_update_len_err: with valid, shifted count != WIDTH
//   io_ctrl_err      : sticky, two or more strobes seen in one cycle
//   io_bypass_active : current latched mode
module jtag_capture_update_chain
  import jtag_chain_pkg::*;
#(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_chainIn_shift,
  input  logic             io_chainIn_data,
  input  logic             io_chainIn_capture,
  input  logic             io_chainIn_update,
  input  logic             io_bypass,
  input  logic [WIDTH-1:0] io_capture_bits,
  input  logic             io_err_clear,
  output logic             io_chainOut_data,
  output logic [WIDTH-1:0] io_update_bits,
  output logic             io_update_valid,
  output logic             io_update_len_err,
  output logic             io_ctrl_err,
  output logic             io_bypass_active
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 2);

  logic             legal;
  logic             cap;
  logic             sh;
  logic             upd;
  logic             accept_upd;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_shifted;
  logic             byp;
  logic [CNT_W-1:0] cnt;
  chain_mode_e      mode;
  chain_mode_e      mode_next;

  // Illegal cycles are masked here so nothing downstream moves.
  always_comb begin
    legal      = strobes_legal(io_chainIn_capture, io_chainIn_shift, io_chainIn_update);
    cap        = legal & io_chainIn_capture;
    sh         = legal & io_chainIn_shift;
    upd        = legal & io_chainIn_update;
    accept_upd = upd & (mode == CHAIN_DATA);
    // Shift/OR form stays valid for WIDTH == 1, where a part-select would not.
    sr_shifted = (sr >> 1) | (WIDTH'(io_chainIn_data) << (WIDTH - 1));
  end

  jtag_shift_counter #(
    .MAX   (WIDTH + 1),
    .CNT_W (CNT_W)
  ) u_shift_counter (
    .clock (clock),
    .reset (reset),
    .clear (cap),
    .inc   (sh),
    .count (cnt)
  );

  // Mode state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mode <= CHAIN_BYPASS;
    end else begin
      mode <= mode_next;
    end
  end

  // Mode next-state.
  always_comb begin
    mode_next = mode;
    if (cap) begin
      mode_next = io_bypass ? CHAIN_BYPASS : CHAIN_DATA;
    end
  end

  // Mode-dependent outputs.
  always_comb begin
    io_bypass_active = (mode == CHAIN_BYPASS);
    io_chainOut_data = (mode == CHAIN_BYPASS) ? byp : sr[0];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sr <= RESET_VALUE;
      byp <= 1'b0;
    end else if (cap) begin
      sr <= io_capture_bits;
      byp <= 1'b0;
    end else if (sh) begin
      if (mode == CHAIN_BYPASS) begin
        byp <= io_chainIn_data;
      end else begin
        sr <= sr_shifted;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      io_update_bits    <= RESET_VALUE;
      io_update_valid   <= 1'b0;
      io_update_len_err <= 1'b0;
    end else begin
      io_update_valid   <= accept_upd;
      io_update_len_err <= accept_upd & (cnt != CNT_W'(WIDTH));
      if (accept_upd) begin
        io_update_bits <= sr;
      end
    end
  end

  // Set dominates clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      io_ctrl_err <= 1'b0;
    end else if (!legal) begin
      io_ctrl_err <= 1'b1;
    end else if (io_err_clear) begin
      io_ctrl_err <= 1'b0;
    end
  end

`ifndef SYNTHESIS
`ifdef ASSERT_VERBOSE_COND
  always @(posedge clock) begin
    if (reset && !legal) begin
      $error("jtag_capture_update_chain: more than one of capture/shift/update asserted");
`ifdef STOP_COND
      $fatal(1, "jtag_capture_update_chain: illegal strobe combination");
`endif
    end
  end
`endif
`endif

endmodule

// File: tb/tb_jtag_capture_update_chain.sv
// Scoreboard bench for jtag_capture_update_chain (WIDTH=8).
module tb_jtag_capture_update_chain;

  localparam int unsigned W  = 8;
  localparam logic [7:0]  RV = 8'h5A;

  logic       clock;
  logic       reset;
  logic       io_chainIn_shift;
  logic       io_chainIn_data;
  logic       io_chainIn_capture;
  logic       io_chainIn_update;
  logic       io_bypass;
  logic [7:0] io_capture_bits;
  logic       io_err_clear;
  logic       io_chainOut_data;
  logic [7:0] io_update_bits;
  logic       io_update_valid;
  logic       io_update_len_err;
  logic       io_ctrl_err;
  logic       io_bypass_active;

  jtag_capture_update_chain #(
    .WIDTH       (W),
    .RESET_VALUE (RV)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .io_chainIn_shift   (io_chainIn_shift),
    .io_chainIn_data    (io_chainIn_data),
    .io_chainIn_capture (io_chainIn_capture),
    .io_chainIn_update  (io_chainIn_update),
    .io_bypass          (io_bypass),
    .io_capture_bits    (io_capture_bits),
    .io_err_clear       (io_err_clear),
    .io_chainOut_data   (io_chainOut_data),
    .io_update_bits     (io_update_bits),
    .io_update_valid    (io_update_valid),
    .io_update_len_err  (io_update_len_err),
    .io_ctrl_err        (io_ctrl_err),
    .io_bypass_active   (io_bypass_active)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic       tdo;
    logic       byp_active;
    logic       err;
    logic [7:0] bits;
    logic       valid;
  } cyc_t;

  typedef struct {
    logic [7:0] bits;
    logic       len_err;
  } upd_t;

  cyc_t exp_cyc[$];
  upd_t exp_upd[$];

  int checks = 0;
  int errors = 0;

  // Reference model: the data register as a number, bypass as one bit,
  // shifted-bit count as a plain integer capped at W+1.
  logic [7:0] m_sr;
  logic       m_byp;
  logic       m_bypass;
  int         m_cnt;
  logic [7:0] m_bits;
  logic       m_valid;
  logic       m_err;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic void model_reset();
    m_sr = RV; m_byp = 1'b0; m_bypass = 1'b1; m_cnt = 0;
    m_bits = RV; m_valid = 1'b0; m_err = 1'b0;
    exp_upd.delete();
  endfunction

  function automatic void push_expect();
    cyc_t e;
    e.tdo        = m_bypass ? m_byp : m_sr[0];
    e.byp_active = m_bypass;
    e.err        = m_err;
    e.bits       = m_bits;
    e.valid      = m_valid;
    exp_cyc.push_back(e);
  endfunction

  function automatic void model_step(input logic c, input logic s, input logic u,
                                     input logic d, input logic b,
                                     input logic [7:0] bits, input logic clr);
    int n;
    upd_t x;
    n = int'(c) + int'(s) + int'(u);
    m_valid = 1'b0;
    if (n > 1) begin
      m_err = 1'b1;
    end else begin
      if (clr) m_err = 1'b0;
      if (c) begin
        m_sr = bits; m_byp = 1'b0; m_cnt = 0; m_bypass = b;
      end else if (s) begin
        if (m_cnt < int'(W) + 1) m_cnt = m_cnt + 1;
        if (m_bypass) m_byp = d;
        else m_sr = (m_sr >> 1) | (d ? 8'h80 : 8'h00);
      end else if (u && !m_bypass) begin
        m_bits  = m_sr;
        m_valid = 1'b1;
        x.bits    = m_sr;
        x.len_err = (m_cnt != int'(W));
        exp_upd.push_back(x);
      end
    end
  endfunction

  task automatic step(input logic c, input logic s, input logic u, input logic d,
                      input logic b, input logic [7:0] bits, input logic clr);
    @(negedge clock);
    reset              = 1'b1;
    io_chainIn_capture = c;
    io_chainIn_shift   = s;
    io_chainIn_update  = u;
    io_chainIn_data    = d;
    io_bypass          = b;
    io_capture_bits    = bits;
    io_err_clear       = clr;
    model_step(c, s, u, d, b, bits, clr);
    push_expect();
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clock);
      reset = 1'b0;
      io_chainIn_capture = 1'b0;
      io_chainIn_shift   = 1'b0;
      io_chainIn_update  = 1'b0;
      io_err_clear       = 1'b0;
      model_reset();
      push_expect();
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 8'h00, 0);
  endtask

  task automatic capture(input logic b, input logic [7:0] bits);
    step(1, 0, 0, 0, b, bits, 0);
  endtask

  task automatic shift_bits(input logic [31:0] data, input int n);
    logic [31:0] v;
    v = data;
    for (int i = 0; i < n; i++) begin
      step(0, 1, 0, v[0], 0, 8'h00, 0);
      v = v >> 1;
    end
  endtask

  task automatic update();
    step(0, 0, 1, 0, 0, 8'h00, 0);
  endtask

  // Monitor: one expectation per driven cycle; update payloads are checked
  // whenever the DUT raises valid.
  always @(posedge clock) begin
    cyc_t e;
    upd_t x;
    #1;
    if (exp_cyc.size() > 0) begin
      e = exp_cyc.pop_front();
      chk("tdo",        32'(io_chainOut_data),  32'(e.tdo));
      chk("bypass",     32'(io_bypass_active),  32'(e.byp_active));
      chk("ctrl_err",   32'(io_ctrl_err),       32'(e.err));
      chk("update_bits",32'(io_update_bits),    32'(e.bits));
      chk("valid",      32'(io_update_valid),   32'(e.valid));
    end
    if (io_update_valid === 1'b1) begin
      checks++;
      if (exp_upd.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid got 1 want 0 at %0t", $time);
      end else begin
        x = exp_upd.pop_front();
        chk("pulse_bits", 32'(io_update_bits),    32'(x.bits));
        chk("len_err",    32'(io_update_len_err), 32'(x.len_err));
      end
    end
  end

  initial begin
    int r;
    logic c, s, u;
    reset = 1'b0;
    io_chainIn_shift = 0; io_chainIn_data = 0; io_chainIn_capture = 0;
    io_chainIn_update = 0; io_bypass = 0; io_capture_bits = '0; io_err_clear = 0;
    model_reset();

    do_reset(2);
    idle(1);

    // Full-length data scan
    capture(0, 8'hA5);
    shift_bits(32'h3C, 8);
    update();
    idle(2);

    // Short scan
    capture(0, 8'hA5);
    shift_bits(32'h3C, 7);
    update();
    idle(1);

    // Long scans: counter saturates rather than wrapping
    capture(0, 8'hA5);
    shift_bits(32'hF0F, 12);
    update();
    capture(0, 8'h33);
    shift_bits(32'hC3A5F1, 24);
    update();
    idle(1);

    // Bypass scan: one-cycle delay, no update pulse
    capture(1, 8'hFF);
    shift_bits(32'b011, 3);
    update();
    idle(2);

    // Illegal strobes and sticky flag
    capture(0, 8'h81);
    step(1, 1, 0, 1, 1, 8'h7E, 0);
    idle(2);
    step(0, 0, 0, 0, 0, 8'h00, 1);
    step(0, 1, 1, 1, 0, 8'h00, 0);
    step(0, 1, 1, 0, 0, 8'h00, 1);
    idle(1);
    step(0, 0, 0, 0, 0, 8'h00, 1);

    // Back-to-back updates, then shift after update without recapture
    capture(0, 8'h00);
    shift_bits(32'hC6, 8);
    update();
    update();
    shift_bits(32'h1, 1);
    update();
    idle(1);

    // Reset mid-scan, right after an update strobe
    capture(0, 8'h5F);
    shift_bits(32'h5, 3);
    update();
    do_reset(2);
    idle(1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      c = 0; s = 0; u = 0;
      if (r < 4) begin
        c = 1'($urandom); s = 1'($urandom); u = 1'($urandom);
        if (int'(c) + int'(s) + int'(u) < 2) begin c = 1; s = 1; end
      end else if (r < 14) c = 1;
      else if (r < 75) s = 1;
      else if (r < 88) u = 1;
      step(c, s, u, 1'($urandom), 1'($urandom_range(0, 3) == 0),
           8'($urandom), $urandom_range(0, 15) == 0);
    end
    idle(3);

    @(negedge clock);
    @(negedge clock);
    chk("cycle_queue_drained",  32'(exp_cyc.size()), 32'd0);
    chk("update_queue_drained", 32'(exp_upd.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
